// File: rtl/l2spm_port_arbiter_pkg.sv
// Shared SoC definitions for the L2 scratchpad: address map and request payload.
package ariane_soc;

  localparam logic [63:0] L2SPMBase      = 64'h1C00_0000;
  localparam logic [63:0] L2SPMLength    = 64'h0000_8000;
  localparam int unsigned L2SPMDataWidth = 64;
  localparam int unsigned L2SPMBeWidth   = L2SPMDataWidth / 8;

  // One requester's payload as seen by the scratchpad port.
  typedef struct packed {
    logic [63:0]                 addr;
    logic                        we;
    logic [L2SPMBeWidth-1:0]     be;
    logic [L2SPMDataWidth-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/l2spm_port_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after prio_i wins.
module rr_prio_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] prio_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan N candidates starting at the priority pointer, wrapping at N.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      int c;
      logic [IdxW-1:0] cidx;
      c = int'(prio_i) + i;
      if (c >= int'(N)) c = c - int'(N);
      cidx = IdxW'(c);
      if (!valid_o && req_i[cidx]) begin
        valid_o     = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/l2spm_port_arbiter.sv
// L2 scratchpad port arbiter: round-robin with short bus locking, address
// checking, and a one-cycle response path in front of a single SRAM macro.
module l2spm_port_arbiter
  import ariane_soc::*;
#(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned DataWidth    = 64,
  parameter logic [63:0] BaseAddr     = L2SPMBase,
  parameter logic [63:0] Length       = L2SPMLength,
  parameter int unsigned MemAddrWidth = $clog2(Length / (DataWidth / 8)),
  parameter int unsigned LockMax      = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0][63:0]              addr_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumReq-1:0]                    lock_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 err_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [MemAddrWidth-1:0]              mem_addr_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  input  logic [DataWidth-1:0]                 mem_rdata_i
);

  localparam int unsigned IdxW     = $clog2(NumReq);
  localparam int unsigned ByteOffW = $clog2(DataWidth / 8);
  localparam int unsigned LockCntW = $clog2(LockMax + 1);

  typedef enum logic {ARB, LOCK} arb_state_e;

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       prio_q, prio_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [LockCntW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NumReq-1:0]     rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic                  rd_q, rd_d;

  logic [NumReq-1:0]     rr_gnt;
  logic [IdxW-1:0]       rr_idx;
  logic                  rr_valid;

  logic [NumReq-1:0]     gnt;
  logic                  gnt_any;
  logic [IdxW-1:0]       sel_idx;
  mem_req_t              sel;
  logic [63:0]           off;
  logic                  legal;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] k);
    if (k == IdxW'(NumReq - 1)) return '0;
    return k + 1'b1;
  endfunction

  rr_prio_select #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_rr (
    .req_i   (req_i),
    .prio_i  (prio_q),
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Arbitration FSM: round-robin in ARB, owner-only grants while LOCK holds.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt        = '0;
    gnt_any    = 1'b0;
    sel_idx    = rr_idx;
    // Reset forces the combinational grant low so the SRAM sees nothing.
    if (rst_ni) begin
      unique case (state_q)
        ARB: begin
          if (rr_valid) begin
            gnt     = rr_gnt;
            gnt_any = 1'b1;
            sel_idx = rr_idx;
            prio_d  = next_idx(rr_idx);
            if (lock_i[rr_idx] && (LockMax > 1)) begin
              state_d    = LOCK;
              owner_d    = rr_idx;
              lock_cnt_d = LockCntW'(1);
            end
          end
        end
        LOCK: begin
          if (req_i[owner_q]) begin
            gnt[owner_q] = 1'b1;
            gnt_any      = 1'b1;
            sel_idx      = owner_q;
            prio_d       = next_idx(owner_q);
            // lock_cnt counts grants already given in this lock, so the
            // grant that brings it to LockMax is the last one.
            if (!lock_i[owner_q] || (lock_cnt_q >= LockCntW'(LockMax - 1))) begin
              state_d    = ARB;
              lock_cnt_d = '0;
            end else begin
              lock_cnt_d = lock_cnt_q + 1'b1;
            end
          end else begin
            state_d    = ARB;
            lock_cnt_d = '0;
          end
        end
        default: begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  // Payload mux, address check and SRAM drive for the granted requester.
  always_comb begin
    sel.addr  = addr_i[sel_idx];
    sel.we    = we_i[sel_idx];
    sel.be    = be_i[sel_idx];
    sel.wdata = wdata_i[sel_idx];
    // The base is aligned, so offset alignment equals address alignment.
    off   = sel.addr - BaseAddr;
    legal = (sel.addr >= BaseAddr) && (off < Length) &&
            (off[ByteOffW-1:0] == '0);
    mem_req_o   = gnt_any & legal;
    mem_we_o    = mem_req_o & sel.we;
    mem_addr_o  = mem_req_o ? off[ByteOffW +: MemAddrWidth] : '0;
    mem_be_o    = mem_req_o ? sel.be : '0;
    mem_wdata_o = mem_req_o ? sel.wdata : '0;
    rvalid_d    = gnt;
    err_d       = gnt_any & ~legal;
    rd_d        = gnt_any & legal & ~sel.we;
  end

  assign gnt_o    = gnt;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  // Only a legal read returns SRAM data; writes and errors return zero.
  assign rdata_o  = rd_q ? mem_rdata_i : '0;

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      prio_q     <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
    end
  end

endmodule

// File: tb/tb_l2spm_port_arbiter.sv
// Self-checking bench for l2spm_port_arbiter: expected responses are queued
// when a grant is expected and compared when rvalid_o should appear.
module tb_l2spm_port_arbiter;

  localparam logic [63:0] BASE = 64'h1C00_0000;

  logic              clk;
  logic              rst_ni;
  logic [3:0]        req_i;
  logic [3:0][63:0]  addr_i;
  logic [3:0]        we_i;
  logic [3:0][7:0]   be_i;
  logic [3:0][63:0]  wdata_i;
  logic [3:0]        lock_i;
  logic [3:0]        gnt_o;
  logic [3:0]        rvalid_o;
  logic [63:0]       rdata_o;
  logic              err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [11:0]       mem_addr_o;
  logic [7:0]        mem_be_o;
  logic [63:0]       mem_wdata_o;
  logic [63:0]       mem_rdata_i;

  typedef struct {
    logic [3:0]  vld;
    logic        err;
    logic [63:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  l2spm_port_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .wdata_i     (wdata_i),
    .lock_i      (lock_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input logic [11:0] w);
    return {20'hC0DE0, w, 20'h5A5A5, w};
  endfunction

  // SRAM stand-in: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (mem_req_o && !mem_we_o) mem_rdata_i <= pat(mem_addr_o);
    else                        mem_rdata_i <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  function automatic logic is_legal(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'h8000) && (a[2:0] == 3'b000);
  endfunction

  function automatic logic [11:0] word_of(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return o[14:3];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_gnt"},    64'(gnt_o), 64'h0);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'h0);
    chk({tag, "_err"},    64'(err_o), 64'h0);
    chk({tag, "_rdata"},  rdata_o, 64'h0);
    chk({tag, "_mreq"},   64'(mem_req_o), 64'h0);
    chk({tag, "_mwe"},    64'(mem_we_o), 64'h0);
    chk({tag, "_maddr"},  64'(mem_addr_o), 64'h0);
    chk({tag, "_mbe"},    64'(mem_be_o), 64'h0);
    chk({tag, "_mwdata"}, mem_wdata_o, 64'h0);
  endtask

  // Compare the response due this cycle, then the grant and SRAM drive,
  // and queue the response the expected grant must produce next cycle.
  task automatic sample(input logic [3:0] eg, input string tag);
    rsp_t r;
    int   k;
    logic lg;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk({tag, "_rvalid"}, 64'(rvalid_o), 64'(r.vld));
      chk({tag, "_err"},    64'(err_o), 64'(r.err));
      chk({tag, "_rdata"},  rdata_o, r.rdata);
    end else begin
      chk({tag, "_rvalid_idle"}, 64'(rvalid_o), 64'h0);
    end
    chk({tag, "_gnt"}, 64'(gnt_o), 64'(eg));
    k = -1;
    for (int i = 0; i < 4; i++) if (eg[i]) k = i;
    if (k < 0) begin
      chk({tag, "_mreq_idle"}, 64'(mem_req_o), 64'h0);
    end else begin
      lg = is_legal(addr_i[k]);
      chk({tag, "_mreq"}, 64'(mem_req_o), 64'(lg));
      if (lg) begin
        chk({tag, "_maddr"}, 64'(mem_addr_o), 64'(word_of(addr_i[k])));
        chk({tag, "_mwe"},   64'(mem_we_o), 64'(we_i[k]));
        if (we_i[k]) begin
          chk({tag, "_mbe"},    64'(mem_be_o), 64'(be_i[k]));
          chk({tag, "_mwdata"}, mem_wdata_o, wdata_i[k]);
        end
      end
      r.vld   = eg;
      r.err   = ~lg;
      r.rdata = (lg && !we_i[k]) ? pat(word_of(addr_i[k])) : 64'h0;
      sb.push_back(r);
    end
  endtask

  task automatic cyc(input logic [3:0] eg, input string tag);
    @(negedge clk);
    sample(eg, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_rst(tag);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = 4'hF;
    lock_i = 4'h0;
    we_i   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      addr_i[i]  = BASE + 64'(8 * (i + 4));
      be_i[i]    = 8'hFF;
      wdata_i[i] = 64'h0;
    end
    // Requests held high during reset must not leak to the outputs.
    do_reset("reset");
    req_i = 4'h0;
    cyc(4'b0000, "idle");

    // Single read from requester 2.
    req_i     = 4'b0100;
    addr_i[2] = BASE + 64'h10;
    cyc(4'b0100, "single");
    req_i = 4'h0;
    cyc(4'b0000, "single_rsp");

    // Full contention from reset: strict rotation, one response per cycle.
    do_reset("reset2");
    req_i = 4'hF;
    for (int n = 0; n < 8; n++) cyc(4'(1 << (n % 4)), $sformatf("rr%0d", n));
    req_i = 4'h0;
    cyc(4'b0000, "rr_drain");

    // Lock timeout: requester 1 keeps lock high while all request.
    req_i  = 4'hF;
    lock_i = 4'b0010;
    cyc(4'b0001, "lk_pre");
    for (int n = 0; n < 16; n++) cyc(4'b0010, $sformatf("lk%0d", n));
    cyc(4'b0100, "lk_after");
    // Owner drops its request while locked: idle cycle, back to ARB.
    lock_i = 4'b1000;
    cyc(4'b1000, "lk3_enter");
    req_i = 4'b0111;
    cyc(4'b0000, "lk3_drop");
    cyc(4'b0001, "lk3_wrap");
    req_i  = 4'h0;
    lock_i = 4'h0;
    cyc(4'b0000, "lk_drain");

    // Illegal addresses: granted, no SRAM access, error response.
    req_i     = 4'b0001;
    addr_i[0] = BASE + 64'h8000;
    cyc(4'b0001, "ill_top");
    addr_i[0] = BASE + 64'h4;
    cyc(4'b0001, "ill_align");
    addr_i[0] = BASE - 64'h8;
    cyc(4'b0001, "ill_below");
    // Last word: legal write, then legal read.
    req_i      = 4'b0010;
    addr_i[1]  = BASE + 64'h7FF8;
    we_i       = 4'b0010;
    be_i[1]    = 8'h0F;
    wdata_i[1] = 64'h1122_3344_5566_7788;
    cyc(4'b0010, "last_wr");
    we_i = 4'h0;
    cyc(4'b0010, "last_rd");
    req_i = 4'h0;
    cyc(4'b0000, "last_drain");

    // Reset while a response is pending.
    do_reset("reset3");
    req_i = 4'hF;
    for (int i = 0; i < 4; i++) addr_i[i] = BASE + 64'(8 * i);
    cyc(4'b0001, "pr0");
    cyc(4'b0010, "pr1");
    @(negedge clk);
    sample(4'b0100, "pr2");
    #1;
    rst_ni = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_rst("in_rst");
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cyc(4'b0001, "post_rst");
    req_i = 4'h0;
    cyc(4'b0000, "post_drain");
    cyc(4'b0000, "end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/l2spm_port_arbiter.md
# l2spm_port_arbiter

Shares the single-port 32 KB L2 scratchpad (base 0x1C00_0000, length 0x8000) among several requesters with a simple req/gnt/rvalid protocol. The block decodes and checks addresses, then arbitrates round-robin with optional short bus locking, and drives one SRAM macro with one-cycle read latency. It sits behind the L2SPM slave port of the SoC crossbar, downstream of the AXI-to-mem converters.

## Interface
- NumReq, 4: number of requesters, 2..8.
- DataWidth, 64: data width in bits; byte enables are DataWidth/8.
- BaseAddr, 64'h1C00_0000: scratchpad base address.
- Length, 64'h8000: scratchpad size in bytes; must be a power of two.
- MemAddrWidth, $clog2(Length/(DataWidth/8)) = 12: word index width.
- LockMax, 16: maximum consecutive locked grants.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- req_i  in  NumReq  per-requester request.
- addr_i  in  NumReq×64  byte address.
- we_i  in  NumReq  write enable.
- be_i  in  NumReq×DataWidth/8  byte enables.
- wdata_i  in  NumReq×DataWidth  write data.
- lock_i  in  NumReq  keep the grant for the next beat.
- gnt_o  out  NumReq  grant, one-hot or zero.
- rvalid_o  out  NumReq  response valid, one-hot or zero.
- rdata_o  out  DataWidth  read data, shared by all requesters.
- err_o  out  1  error flag, qualified by rvalid_o.
- mem_req_o  out  1  SRAM access.
- mem_we_o  out  1  SRAM write.
- mem_addr_o  out  MemAddrWidth  SRAM word index: (addr − BaseAddr) >> log2(DataWidth/8).
- mem_be_o  out  DataWidth/8  SRAM byte enables.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_rdata_i  in  DataWidth  SRAM read data, valid one cycle after mem_req_o.

## Operation
- **Grant.** At most one gnt_o bit per cycle, combinational from req_i and state. A requester's request is accepted in any cycle where its req_i and gnt_o are both high. A requester holds req_i and its payload until granted.
- **Round-robin.** A registered pointer `prio_q` holds the highest-priority index. After a grant to index k, `prio_q` becomes (k+1) mod NumReq.
- **States.** The FSM has two states, ARB and LOCK.
  - ARB: normal round-robin. A grant to k with lock_i[k]=1 moves to LOCK with owner=k and lock_cnt=1.
  - LOCK: only the owner can be granted. If req_i[owner]=0, nothing is granted and the FSM returns to ARB.
  - A LOCK grant with lock_i[owner]=0, or with lock_cnt reaching LockMax, returns to ARB. `prio_q` becomes owner+1.
  - Otherwise a LOCK grant increments lock_cnt.
- **Address check.** An access is illegal if addr < BaseAddr, addr ≥ BaseAddr+Length, or addr is not aligned to DataWidth/8. Illegal accesses are still granted, but mem_req_o stays 0.
- **Response.**
  - rvalid_o[k] is asserted exactly one cycle after gnt_o[k], for both reads and writes.
  - rdata_o = mem_rdata_i for a legal read; 0 otherwise.
  - err_o = 1 for an illegal access.
  - The response owner and error flag are registered.
- **Memory outputs.** mem_* carry the granted requester's payload and are 0 when there is no grant.

## Timing
- Throughput is one access per cycle; back-to-back grants to different requesters are allowed.
- Latency from grant to rvalid is 1 cycle and is fixed; there is no backpressure on responses.
- **Reset values.**
  - gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, mem_*=0.
  - prio_q=0, state=ARB, lock_cnt=0.
- **Reset mid-operation.** A pending response is dropped and no rvalid_o is issued after reset is released.
- **Simultaneous requests.** With all req_i high and no lock, grants rotate 0,1,2,3,0,… starting from prio_q.
- **Wrap-around.** A grant to index NumReq−1 sets prio_q to 0.
- **Lock timeout.** LockMax consecutive owner grants are allowed, then ARB is forced for one arbitration, even if lock_i stays high.
- **Boundary address.** addr = BaseAddr+Length−8 is legal (word 4095); addr = BaseAddr+Length is illegal.

## Structure
- **Shared package** (ariane_soc): L2SPMBase, L2SPMLength, and a `mem_req_t` struct {addr, we, be, wdata}.
- **Local enum** `arb_state_e` {ARB, LOCK}.
- **Sub-module** `rr_prio_select`: the combinational round-robin pick (req, prio → one-hot gnt, idx). It is instantiated once.
- **This module** holds the FSM, lock counter, address check and response registers.

## Test plan
1. **Single read.** req_i[2]=1, addr=0x1C00_0010, we=0 → gnt_o=4'b0100 and mem_addr_o=2 the same cycle; the next cycle rvalid_o=4'b0100, rdata_o=mem_rdata_i, err_o=0.
2. **Full contention.** All four requesting continuously for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3 with one rvalid per cycle, each one cycle after its grant.
3. **Lock timeout.** Requester 1 holds lock_i=1 with all others requesting → 16 consecutive grants to 1, then a grant to 2.
4. **Illegal addresses.** addr=0x1C00_8000 and addr=0x1C00_0004 → granted, mem_req_o=0, next cycle err_o=1 with rdata_o=0. Also write addr=0x1C00_7FF8, be=0x0F → mem_addr_o=4095, mem_be_o=0x0F, err_o=0.
5. **Reset during access.** rst_ni is deasserted the cycle after a grant → no rvalid_o is issued, all outputs read 0, and the first post-reset grant goes to the lowest-index requester.
